// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF response generator:
// default sizes, FSM state encoding and challenge field positions.
package ro_puf_pkg;

  localparam int DEF_N_RO   = 16;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WINDOW = 1024;

  // Challenge layout is {sel_a, sel_b}; field index times SEL_W gives the LSB.
  localparam int CH_SEL_A_IDX = 1;
  localparam int CH_SEL_B_IDX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2
  } state_t;

endpackage

// File: rtl/ro_puf_response_gen_ro_edge_counter.sv
// Rising-edge counter for one selected ring-oscillator output.
// Optional feature macro: RO_PUF_SYNC_EN adds a 2-flop synchronizer
// in front of the edge detector.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_in,
  input  logic             clear,
  input  logic             load,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  logic             sample;
  logic             hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rising;

`ifdef RO_PUF_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer stages run freely so stage 2 is settled when a window opens.
  always_comb begin
    sync1_d = ro_in;
    sync2_d = sync1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = ro_in;
`endif

  assign rising = ~hist_q & sample;

  // History tracks the sample only while loading or counting; counter saturates.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (load || count_en) begin
      hist_d = sample;
    end
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && rising && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Edge-history and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ro_puf_response_gen.sv
// Ring-oscillator PUF response generator: measures two selected oscillators
// over a fixed clock window and compares their edge counts.
// Optional feature macro: RO_PUF_SYNC_EN (synchronizer inside ro_edge_counter).
module ro_puf_response_gen
  import ro_puf_pkg::*;
#(
  parameter int N_RO   = DEF_N_RO,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_RO-1:0]    ro_out,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  output logic               ro_enable,
  output logic               busy,
  output logic               response_valid,
  output logic               response,
  output logic               tie,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_a_q, sel_a_d;
  logic [SEL_W-1:0]   sel_b_q, sel_b_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               ro_enable_q, ro_enable_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               response_q, response_d;
  logic               tie_q, tie_d;

  logic               accept;
  logic               counting;
  logic [SEL_W-1:0]   mux_sel_a, mux_sel_b;
  logic [CNT_W-1:0]   cnt_a, cnt_b;

  assign accept   = (state_q == IDLE) && start;
  assign counting = (state_q == RUN);

  // While idle the incoming challenge drives the mux so history loads from the new pair.
  always_comb begin
    mux_sel_a = sel_a_q;
    mux_sel_b = sel_b_q;
    if (state_q == IDLE) begin
      mux_sel_a = challenge[CH_SEL_A_IDX*SEL_W +: SEL_W];
      mux_sel_b = challenge[CH_SEL_B_IDX*SEL_W +: SEL_W];
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst      (rst),
    .ro_in    (ro_out[mux_sel_a]),
    .clear    (accept),
    .load     (accept),
    .count_en (counting),
    .count    (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst      (rst),
    .ro_in    (ro_out[mux_sel_b]),
    .clear    (accept),
    .load     (accept),
    .count_en (counting),
    .count    (cnt_b)
  );

  // Next-state logic: accept in IDLE, run WINDOW cycles, compare for one cycle.
  always_comb begin
    state_d     = state_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    win_d       = win_q;
    ro_enable_d = ro_enable_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    response_d  = response_q;
    tie_d       = tie_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          sel_a_d     = challenge[CH_SEL_A_IDX*SEL_W +: SEL_W];
          sel_b_d     = challenge[CH_SEL_B_IDX*SEL_W +: SEL_W];
          win_d       = '0;
          ro_enable_d = 1'b1;
          busy_d      = 1'b1;
          response_d  = 1'b0;
          tie_d       = 1'b0;
        end
      end
      RUN: begin
        win_d = win_q + 1'b1;
        if (win_q == WIN_W'(WINDOW - 1)) begin
          state_d     = CMP;
          ro_enable_d = 1'b0;
        end
      end
      CMP: begin
        response_d = (cnt_a > cnt_b);
        tie_d      = (cnt_a == cnt_b);
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d     = IDLE;
        ro_enable_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      win_q       <= '0;
      ro_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      response_q  <= 1'b0;
      tie_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      win_q       <= win_d;
      ro_enable_q <= ro_enable_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      response_q  <= response_d;
      tie_q       <= tie_d;
    end
  end

  assign ro_enable      = ro_enable_q;
  assign busy           = busy_q;
  assign response_valid = valid_q;
  assign response       = response_q;
  assign tie            = tie_q;
  assign count_a        = cnt_a;
  assign count_b        = cnt_b;

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Directed bench for ro_puf_response_gen with clk-synchronous oscillator models.
module tb_ro_puf_response_gen;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ro_out;
  logic        start, start2;
  logic [7:0]  challenge, challenge2;
  logic [7:0]  tick;

  logic        ro_enable, busy, response_valid, response, tie;
  logic [15:0] count_a, count_b;
  logic        ro_enable2, busy2, response_valid2, response2, tie2;
  logic [3:0]  count_a2, count_b2;

  int checks = 0;
  int errors = 0;

  int          valid_cycle, pulses;
  logic        cap_resp, cap_tie;
  logic [15:0] cap_a, cap_b;
  logic        en_run, en_cmp, busy_cmp, busy_after;

  ro_puf_response_gen #(.CNT_W(16), .WINDOW(W)) dut (
    .clk(clk), .rst(rst), .ro_out(ro_out), .start(start), .challenge(challenge),
    .ro_enable(ro_enable), .busy(busy), .response_valid(response_valid),
    .response(response), .tie(tie), .count_a(count_a), .count_b(count_b)
  );

  ro_puf_response_gen #(.CNT_W(4), .WINDOW(W)) dut2 (
    .clk(clk), .rst(rst), .ro_out(ro_out), .start(start2), .challenge(challenge2),
    .ro_enable(ro_enable2), .busy(busy2), .response_valid(response_valid2),
    .response(response2), .tie(tie2), .count_a(count_a2), .count_b(count_b2)
  );

  always #5 clk = ~clk;

  // Oscillator models: bit 0/7 period 2, bit 3 period 4, bit 5 period 8; others idle low.
  initial begin
    tick   = '0;
    ro_out = '0;
    forever begin
      @(negedge clk);
      tick = tick + 1'b1;
      ro_out    = '0;
      ro_out[0] = tick[0];
      ro_out[3] = tick[1];
      ro_out[5] = tick[2];
      ro_out[7] = tick[0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a measurement and watch the following W+3 cycles for the response pulse.
  task automatic applyStimulus(input bit use2, input logic [7:0] chal, input bit disturb);
    logic v;
    @(posedge clk); #1;
    if (use2) begin
      challenge2 = chal;
      start2     = 1'b1;
    end else begin
      challenge = chal;
      start     = 1'b1;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
    valid_cycle = -1;
    pulses      = 0;
    for (int m = 1; m <= W + 3; m++) begin
      @(posedge clk); #1;
      v = use2 ? response_valid2 : response_valid;
      if (v) begin
        pulses++;
        if (valid_cycle < 0) begin
          valid_cycle = m;
          cap_resp = use2 ? response2 : response;
          cap_tie  = use2 ? tie2 : tie;
          cap_a    = use2 ? {12'b0, count_a2} : count_a;
          cap_b    = use2 ? {12'b0, count_b2} : count_b;
        end
      end
      if (m == 1) en_run = use2 ? ro_enable2 : ro_enable;
      if (m == W) begin
        en_cmp   = use2 ? ro_enable2 : ro_enable;
        busy_cmp = use2 ? busy2 : busy;
      end
      if (m == W + 1) busy_after = use2 ? busy2 : busy;
      if (disturb && m == 10) begin
        start     = 1'b1;
        challenge = 8'h77;
      end
      if (disturb && m == 11) start = 1'b0;
    end
  endtask

  task automatic checkResult(input string tag, input int exp_a, input int exp_b,
                             input bit exp_resp, input bit exp_tie);
    checkOutput({tag, "_valid_cycle"}, valid_cycle, W + 1);
    checkOutput({tag, "_pulses"}, pulses, 1);
    checkOutput({tag, "_count_a"}, {16'b0, cap_a}, exp_a);
    checkOutput({tag, "_count_b"}, {16'b0, cap_b}, exp_b);
    checkOutput({tag, "_response"}, {31'b0, cap_resp}, {31'b0, exp_resp});
    checkOutput({tag, "_tie"}, {31'b0, cap_tie}, {31'b0, exp_tie});
    checkOutput({tag, "_en_run"}, {31'b0, en_run}, 1);
    checkOutput({tag, "_en_cmp"}, {31'b0, en_cmp}, 0);
    checkOutput({tag, "_busy_cmp"}, {31'b0, busy_cmp}, 1);
    checkOutput({tag, "_busy_after"}, {31'b0, busy_after}, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start2     = 1'b0;
    challenge  = '0;
    challenge2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ro_enable", {31'b0, ro_enable}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_valid", {31'b0, response_valid}, 0);
    checkOutput("rst_response", {31'b0, response}, 0);
    checkOutput("rst_tie", {31'b0, tie}, 0);
    checkOutput("rst_count_a", {16'b0, count_a}, 0);
    checkOutput("rst_count_b", {16'b0, count_b}, 0);
    rst = 1'b0;

    $display("[TB] pair (3,5)");
    applyStimulus(1'b0, 8'h35, 1'b0);
    checkResult("t1", 16, 8, 1'b1, 1'b0);

    $display("[TB] pair (5,3)");
    applyStimulus(1'b0, 8'h53, 1'b0);
    checkResult("t2", 8, 16, 1'b0, 1'b0);

    $display("[TB] pair (7,7)");
    applyStimulus(1'b0, 8'h77, 1'b0);
    checkResult("t3", 32, 32, 1'b0, 1'b1);

    $display("[TB] saturation with 4-bit counters");
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkResult("t4", 15, 0, 1'b1, 1'b0);

    $display("[TB] reset mid-measurement");
    @(posedge clk); #1;
    challenge = 8'h35;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5_busy", {31'b0, busy}, 0);
    checkOutput("t5_ro_enable", {31'b0, ro_enable}, 0);
    checkOutput("t5_count_a", {16'b0, count_a}, 0);
    checkOutput("t5_count_b", {16'b0, count_b}, 0);
    checkOutput("t5_valid", {31'b0, response_valid}, 0);
    rst    = 1'b0;
    pulses = 0;
    for (int m = 0; m < W + 5; m++) begin
      @(posedge clk); #1;
      if (response_valid) pulses++;
    end
    checkOutput("t5_no_valid", pulses, 0);
    applyStimulus(1'b0, 8'h53, 1'b0);
    checkResult("t5_after", 8, 16, 1'b0, 1'b0);

    $display("[TB] start and challenge change during RUN");
    applyStimulus(1'b0, 8'h35, 1'b1);
    checkResult("t6", 16, 8, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
